ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the execute stage.
- Consumes the operands and decoded op that the ID/EX pipeline register delivers to execute.
- Requests a pipeline stall while an operation is in flight, then presents the 64-bit result to the execute-stage writeback mux.
- Sits directly downstream of the ID/EX register, alongside the ALU.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- flush  input  1  kill the in-flight op (branch/trap redirect).
- start  input  1  execute-stage instruction is an M-extension op with valid operands.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- is_word  input  1  W-variant (MULW/DIVW/DIVUW/REMW/REMUW).
- op1  input  XLEN  rs1 value.
- op2  input  XLEN  rs2 value.
- busy  output  1  state is not IDLE.
- stall_req  output  1  hold IF/ID/EX; feeds the stall controller.
- done  output  1  one-cycle pulse; result is valid.
- result  output  XLEN  final result; held until the next done.

Behaviour:
- Reset (rst==0 at a clock edge):
  - state goes to IDLE; done=0, result=0, counter=0.
  - Any in-flight op is discarded, with no done.
- States and transitions:
  - IDLE -> CALC when start=1 and no special case applies.
  - IDLE -> DONE when start=1 and a special case applies.
  - CALC -> DONE when the counter reaches N-1.
  - DONE -> IDLE unconditionally.
- N (iteration count): 64, or 32 when is_word=1.
- start is sampled only in IDLE and ignored in CALC/DONE. Operands, funct3 and is_word are latched at the start edge; later input changes have no effect.
- Latency: start sampled at edge t; CALC occupies edges t+1..t+N; done=1 and result valid in the cycle after edge t+N. Special cases assert done in the cycle after edge t.
- stall_req = (state==IDLE && start) || state==CALC. It is deasserted in DONE, so the instruction advances with done=1.
- Multiply:
  - Shift-add on operand magnitudes, 1 bit/cycle, into a 2*XLEN accumulator.
  - Sign fix-up by op: MULH both operands signed; MULHSU op1 signed, op2 unsigned; MULHU unsigned.
  - MUL returns product[63:0]; MULH/MULHSU/MULHU return product[127:64].
  - is_word with funct3 000..011 is treated as MULW: product of op1[31:0] and op2[31:0], low 32 bits sign-extended.
- Divide:
  - Restoring divider on magnitudes, 1 quotient bit/cycle.
  - Quotient is negated when signed and the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Word ops use the low 32 bits (sign- or zero-extended per signedness); the 32-bit result is sign-extended to 64.
- Special cases (resolved at start, no iteration):
  - Divide by zero: DIV/DIVU give all ones (W variants give 0xFFFFFFFFFFFFFFFF); REM/REMU give the dividend (sign-extended for W).
  - Signed overflow (most-negative / -1): DIV gives the dividend; REM gives 0.
- flush:
  - In CALC or DONE: next state is IDLE, done stays 0, result is unchanged.
  - flush and start in the same IDLE cycle: start is ignored.
  - flush has priority over every transition.
- Reset mid-operation: identical to power-up reset.

Optional Feature:
- Macro: EX_MULDIV_FAST_MUL_EN.
- Defined: multiplies compute in a single cycle using the synthesis multiplier; IDLE -> DONE directly, done in the cycle after start; stall_req is high only in the start cycle. Divides are unchanged.
- Undefined: all multiplies are iterative as specified above.

Test Plan:
- MUL op1=3, op2=0xFFFFFFFFFFFFFFFB, start at edge t -> stall_req high until DONE; done at cycle after t+64; result=0xFFFFFFFFFFFFFFF1.
- MULHU op1=0xFFFFFFFFFFFFFFFF, op2=2 -> result=0x0000000000000001; MULH with the same operands -> result=0xFFFFFFFFFFFFFFFF.
- REMU op1=100, op2=7 -> result=2 after 64 iterations; DIVW op1=0xFFFFFFF9, op2=2 -> result=0xFFFFFFFFFFFFFFFD, done after 32 iterations.
- DIV op2=0 -> done in the cycle after start, result=0xFFFFFFFFFFFFFFFF; REM op1=0x1234, op2=0 -> result=0x1234.
- DIVW op1=0x80000000, op2=0xFFFFFFFF -> result=0xFFFFFFFF80000000; REMW with the same operands -> result=0.
- DIV started, flush at iteration 10 -> IDLE next cycle, no done pulse, stall_req low. A new start 1 cycle later completes correctly. rst=0 mid-CALC -> done=0, result=0.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the execute stage: shift-add multiplier,
// restoring divider. Optional single-cycle multiply when EX_MULDIV_FAST_MUL_EN is defined.
module ex_muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int HALF = XLEN / 2;
  localparam int W2   = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              word_q, word_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
    return {{(XLEN-HALF){v[HALF-1]}}, v};
  endfunction

  // Operand preparation from the ID/EX inputs, used only on the start cycle
  logic            div_op, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, dvd_sx, special_res;

  always_comb begin
    div_op   = funct3[2];
    sgn_a    = div_op ? ~funct3[0] : (~is_word && (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10));
    sgn_b    = div_op ? ~funct3[0] : (~is_word && funct3[1:0] == 2'b01);
    a_ext    = is_word ? {{(XLEN-HALF){sgn_a & op1[HALF-1]}}, op1[HALF-1:0]} : op1;
    b_ext    = is_word ? {{(XLEN-HALF){sgn_b & op2[HALF-1]}}, op2[HALF-1:0]} : op2;
    a_neg    = sgn_a & a_ext[XLEN-1];
    b_neg    = sgn_b & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    min_neg  = is_word ? sext_half({1'b1, {(HALF-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = div_op && (b_ext == '0);
    div_ovf  = div_op && ~funct3[0] && (a_ext == min_neg) && (b_ext == '1);
    dvd_sx   = is_word ? sext_half(op1[HALF-1:0]) : op1;
    if (div_zero) special_res = funct3[1] ? dvd_sx : '1;
    else          special_res = funct3[1] ? '0 : dvd_sx;
  end

`ifdef EX_MULDIV_FAST_MUL_EN
  logic [W2-1:0]   fast_raw;
  logic [XLEN-1:0] fast_lo, fast_hi, fast_res;

  always_comb begin
    fast_raw = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_lo  = fast_raw[XLEN-1:0];
    fast_hi  = (a_neg ^ b_neg) ? (~fast_raw[W2-1:XLEN] + XLEN'(fast_raw[XLEN-1:0] == '0))
                               : fast_raw[W2-1:XLEN];
    if (is_word)                  fast_res = sext_half(fast_lo[HALF-1:0]);
    else if (funct3[1:0] == 2'b00) fast_res = fast_lo;
    else                           fast_res = fast_hi;
  end
`endif

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ge;
  logic [W2-1:0]   mul_nx, div_nx, step_acc;
  logic [XLEN-1:0] fin_q, fin_r, div_v, div_res, prod_hi, mul_res, fin_res;
  logic [CNT_W-1:0] n_last;

  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_ge   = ~div_diff[XLEN];
    div_nx   = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    step_acc = f3_q[2] ? div_nx : mul_nx;

    fin_q    = step_acc[XLEN-1:0];
    fin_r    = step_acc[W2-1:XLEN];
    div_v    = f3_q[1] ? (negr_q ? -fin_r : fin_r) : (negq_q ? -fin_q : fin_q);
    div_res  = word_q ? sext_half(div_v[HALF-1:0]) : div_v;

    // High half of the two's-complement negation: ~hi plus the carry out of -lo
    prod_hi  = negq_q ? (~step_acc[W2-1:XLEN] + XLEN'(step_acc[XLEN-1:0] == '0))
                      : step_acc[W2-1:XLEN];
    // A word multiply of N=HALF steps leaves its low product bits in acc[XLEN-1:HALF]
    if (word_q)                  mul_res = sext_half(step_acc[XLEN-1:HALF]);
    else if (f3_q[1:0] == 2'b00) mul_res = step_acc[XLEN-1:0];
    else                         mul_res = prod_hi;
    fin_res  = f3_q[2] ? div_res : mul_res;
    n_last   = word_q ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    word_d   = word_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          f3_d   = funct3;
          word_d = is_word;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            done_d   = 1'b1;
            state_d  = S_DONE;
`ifdef EX_MULDIV_FAST_MUL_EN
          end else if (!div_op) begin
            result_d = fast_res;
            done_d   = 1'b1;
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
            if (div_op) begin
              acc_d  = {{XLEN{1'b0}}, (is_word ? {a_mag[HALF-1:0], {(XLEN-HALF){1'b0}}} : a_mag)};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{XLEN{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == n_last) begin
          cnt_d    = '0;
          result_d = fin_res;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      word_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      word_q   <= word_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Handshake: stall_req holds the pipeline from the start cycle until DONE, where
  // it drops so the instruction advances in the same cycle that done pulses.
  always_comb begin
    busy      = (state_q != S_IDLE);
    stall_req = ((state_q == S_IDLE) && start) || (state_q == S_CALC);
    done      = done_q;
    result    = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized ops scored
// against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int MAX_WAIT = 200;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic [2:0]  funct3;
  logic        is_word;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [63:0] result;

  int          checks;
  int          errors;
  logic [63:0] last_res;
  logic [63:0] exp_q[$];

  ex_muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .funct3    (funct3),
    .is_word   (is_word),
    .op1       (op1),
    .op2       (op2),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    if (!f3[2]) return 1'b0;
    if (w) return (b[31:0] == 32'd0) ||
                  (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (is_special(f3, w, a, b)) return 1;
`ifdef EX_MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, pp;
    logic [63:0] q, r;
    longint sa, sb;
    int sa32, sb32;
    if (!f3[2]) begin
      if (w) return sx32(a[31:0] * b[31:0]);
      pa = (f3[1:0] == 2'b01 || f3[1:0] == 2'b10) ? {{64{a[63]}}, a} : {64'd0, a};
      pb = (f3[1:0] == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
      pp = pa * pb;
      return (f3[1:0] == 2'b00) ? pp[63:0] : pp[127:64];
    end
    if (w) begin
      if (b[31:0] == 32'd0) begin
        q = '1; r = sx32(a[31:0]);
      end else if (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q = sx32(a[31:0]); r = 64'd0;
      end else if (!f3[0]) begin
        sa32 = a[31:0]; sb32 = b[31:0];
        q = sx32(sa32 / sb32); r = sx32(sa32 % sb32);
      end else begin
        q = sx32(a[31:0] / b[31:0]); r = sx32(a[31:0] % b[31:0]);
      end
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0;
      end else if (!f3[0]) begin
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
      end else begin
        q = a / b; r = a % b;
      end
    end
    return f3[1] ? r : q;
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: issue one op, scramble inputs while it runs, then score it
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input string tag);
    int lat;
    int exp_lat;
    logic stall_bad;
    logic [63:0] exp;
    exp_q.push_back(exp_res);
    exp_lat = ref_lat(f3, w, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f3; is_word = w; op1 = a; op2 = b;
    #1 stall_bad = (stall_req !== 1'b1);
    lat = 0;
    for (int k = 1; k <= MAX_WAIT && lat == 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) lat = k;
      else begin
        if (stall_req !== 1'b1 || busy !== 1'b1) stall_bad = 1'b1;
        start   = 1'($urandom_range(0, 1));
        funct3  = 3'($urandom_range(0, 7));
        is_word = 1'($urandom_range(0, 1));
        op1     = {$urandom, $urandom};
        op2     = {$urandom, $urandom};
      end
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " stall"}, {63'd0, stall_bad | stall_req}, 64'd0);
    last_res = exp;
    @(negedge clk);
    check({tag, " pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  task automatic launch(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    start = 1'b1; funct3 = f3; is_word = 1'b0; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    int          sel;
    checks = 0; errors = 0; last_res = 64'd0;
    rst = 1'b0; flush = 1'b0; start = 1'b0; funct3 = 3'd0; is_word = 1'b0;
    op1 = 64'd0; op2 = 64'd0;
    repeat (3) @(negedge clk);
    check("reset outputs", {61'd0, done, busy, stall_req}, 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b1;

    run_op(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, "mul neg");
    run_op(3'b011, 1'b0, '1, 64'd2, 64'h0000_0000_0000_0001, "mulhu");
    run_op(3'b001, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "mulh");
    run_op(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, "remu");
    run_op(3'b100, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "divw");
    run_op(3'b100, 1'b0, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "div by zero");
    run_op(3'b110, 1'b0, 64'h1234, 64'd0, 64'h1234, "rem by zero");
    run_op(3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, "divw ovf");
    run_op(3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, "remw ovf");
    run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, "div ovf");

    // Flush mid-divide: back to IDLE, no done, result held
    launch(3'b100, 64'd1000, 64'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush idle", {61'd0, done, busy, stall_req}, 64'd0);
    check("flush result", result, last_res);
    expect_quiet("flush no done", 70);
    run_op(3'b100, 1'b0, 64'd1000, 64'd7, 64'd142, "after flush");

    // Flush together with start: start ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; op1 = 64'd9; op2 = 64'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush start busy", {62'd0, busy, done}, 64'd0);
    expect_quiet("flush start no done", 5);

    // Reset mid-calculation
    launch(3'b000, 64'd5, 64'd7);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midreset outputs", {62'd0, done, busy}, 64'd0);
    check("midreset result", result, 64'd0);
    expect_quiet("midreset no done", 70);
    run_op(3'b000, 1'b0, 64'd5, 64'd7, 64'd35, "after reset");

    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      w   = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom} >> $urandom_range(0, 62);
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 64'd0;
      else if (sel == 1) begin
        a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        b = '1;
      end else if (sel == 2) begin
        a = 64'($urandom_range(0, 1000));
        b = 64'($urandom_range(1, 20));
      end else if (sel == 3) a = -a;
      run_op(f3, w, a, b, ref_result(f3, w, a, b), $sformatf("rand%0d f3=%0d w=%0d", i, f3, w));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
